// File: rtl/lfsr_gene_source.sv
// lfsr_gene_source: loads a per-individual seed slice into a Galois LFSR and
// serves bounded random gene values over a request/valid handshake.
module lfsr_gene_source #(
  parameter int                SEED_W      = 4096,
  parameter int                LFSR_W      = 32,
  parameter int                GENE_W      = 8,
  parameter logic [LFSR_W-1:0] DEFAULT_TAP = 32'h80200003
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [SEED_W-1:0] Seed,
  input  logic [SEED_W-1:0] Tap,
  input  logic              seedIsReady,
  input  logic [7:0]        populationCounter,
  input  logic              gene_req,
  input  logic [GENE_W-1:0] gene_max,
  output logic [GENE_W-1:0] gene_value,
  output logic              gene_valid,
  output logic              rng_ready,
  output logic [1:0]        state_rng
);

  localparam int NSLICE = SEED_W / LFSR_W;
  localparam int IDX_W  = $clog2(NSLICE);
  localparam int CNT_W  = $clog2(GENE_W + 1);
  localparam logic [CNT_W-1:0]  STEPS   = CNT_W'(GENE_W);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [GENE_W:0]   MOD_ONE = (GENE_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_BUSY = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [LFSR_W-1:0]   tapword_q, tapword_d;
  logic [7:0]          pc_q, pc_d;
  logic [GENE_W:0]     mod_q, mod_d;
  logic [GENE_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    stepcnt_q, stepcnt_d;
  logic [GENE_W-1:0]   gene_value_q, gene_value_d;
  logic                gene_valid_q, gene_valid_d;

  // Seed vector viewed as an array of LFSR-sized slices, one per individual.
  logic [LFSR_W-1:0] seed_slices [NSLICE];
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    assign seed_slices[gi] = Seed[gi*LFSR_W +: LFSR_W];
  end

  logic [IDX_W-1:0]  slice_idx;
  logic [LFSR_W-1:0] slice_sel;
  logic [LFSR_W-1:0] tap_top;
  logic [LFSR_W-1:0] lfsr_step;
  logic              stepping;
  logic              acc_ge_mod;
  logic              pc_changed;
  logic              tap_unused_bits;

  assign slice_idx  = populationCounter[IDX_W-1:0];
  assign slice_sel  = seed_slices[slice_idx];
  assign tap_top    = Tap[SEED_W-1 -: LFSR_W];
  // Only the top word of Tap carries feedback taps.
  assign tap_unused_bits = ^Tap[SEED_W-LFSR_W-1:0];
  assign lfsr_step  = lfsr_q[0] ? ((lfsr_q >> 1) ^ tapword_q) : (lfsr_q >> 1);
  assign stepping   = (stepcnt_q < STEPS);
  assign acc_ge_mod = ({1'b0, acc_q} >= mod_q);
  assign pc_changed = (populationCounter != pc_q);

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= '0;
      tapword_q    <= '0;
      pc_q         <= '0;
      mod_q        <= '0;
      acc_q        <= '0;
      stepcnt_q    <= '0;
      gene_value_q <= '0;
      gene_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      tapword_q    <= tapword_d;
      pc_q         <= pc_d;
      mod_q        <= mod_d;
      acc_q        <= acc_d;
      stepcnt_q    <= stepcnt_d;
      gene_value_q <= gene_value_d;
      gene_valid_q <= gene_valid_d;
    end
  end

  // Next state: losing seedIsReady overrides everything; re-seed beats a request.
  always_comb begin
    state_d = state_q;
    if (!seedIsReady) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_LOAD;
        S_LOAD: state_d = S_RUN;
        S_RUN: begin
          if (pc_changed)    state_d = S_LOAD;
          else if (gene_req) state_d = S_BUSY;
        end
        S_BUSY: begin
          if (!stepping && !acc_ge_mod) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: seed load, draw acceptance, LFSR stepping and restoring modulo.
  always_comb begin
    lfsr_d       = lfsr_q;
    tapword_d    = tapword_q;
    pc_d         = pc_q;
    mod_d        = mod_q;
    acc_d        = acc_q;
    stepcnt_d    = stepcnt_q;
    gene_value_d = gene_value_q;
    gene_valid_d = 1'b0;
    if (seedIsReady) begin
      case (state_q)
        S_LOAD: begin
          // An all-zero seed would lock the LFSR at zero forever.
          lfsr_d    = (slice_sel == '0) ? LFSR_W'(1) : slice_sel;
          tapword_d = (tap_top == '0) ? DEFAULT_TAP : tap_top;
          pc_d      = populationCounter;
        end
        S_RUN: begin
          if (!pc_changed && gene_req) begin
            mod_d     = {1'b0, gene_max} + MOD_ONE;
            stepcnt_d = '0;
          end
        end
        S_BUSY: begin
          if (stepping) begin
            lfsr_d    = lfsr_step;
            stepcnt_d = stepcnt_q + CNT_ONE;
            if (stepcnt_q == STEPS - CNT_ONE) acc_d = lfsr_step[GENE_W-1:0];
          end else if (acc_ge_mod) begin
            // acc >= mod implies mod fits in GENE_W bits here.
            acc_d = acc_q - mod_q[GENE_W-1:0];
          end else begin
            gene_value_d = acc_q;
            gene_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state plus the registered draw result.
  always_comb begin
    rng_ready  = (state_q == S_RUN);
    state_rng  = state_q;
    gene_value = gene_value_q;
    gene_valid = gene_valid_q;
  end

endmodule

// File: tb/tb_lfsr_gene_source.sv
// Self-checking bench for lfsr_gene_source: directed table, random draws
// against a behavioural model, and hand-written multi-cycle corner cases.
module tb_lfsr_gene_source;

  localparam int SEED_W = 4096;
  localparam int LFSR_W = 32;
  localparam int GENE_W = 8;
  localparam logic [31:0] DEF_TAP = 32'h80200003;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [SEED_W-1:0] seed_bus;
  logic [SEED_W-1:0] tap_bus;
  logic              seed_rdy;
  logic [7:0]        pc;
  logic              gene_req;
  logic [7:0]        gene_max;
  logic [7:0]        gene_value;
  logic              gene_valid;
  logic              rng_ready;
  logic [1:0]        state_rng;

  int n_vec  = 0;
  int n_miss = 0;

  // Model state: current LFSR contents and tap word.
  logic [31:0] m_lfsr;
  logic [31:0] m_tap;

  typedef struct {
    logic [31:0] slice;
    logic [31:0] tapw;
    logic [7:0]  gmax;
    logic [7:0]  exp_val;
    int          exp_lat;
  } vec_t;
  vec_t vecs [5];

  lfsr_gene_source dut (
    .CLOCK_50          (clk),
    .reset             (rst_n),
    .Seed              (seed_bus),
    .Tap               (tap_bus),
    .seedIsReady       (seed_rdy),
    .populationCounter (pc),
    .gene_req          (gene_req),
    .gene_max          (gene_max),
    .gene_value        (gene_value),
    .gene_valid        (gene_valid),
    .rng_ready         (rng_ready),
    .state_rng         (state_rng)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model: seed from slice (pc mod 128), zero slice -> 1, zero tap -> default.
  task automatic model_seed(input logic [7:0] p);
    int idx;
    logic [31:0] s;
    logic [31:0] t;
    idx = int'(p) % (SEED_W / LFSR_W);
    s = seed_bus[idx*LFSR_W +: LFSR_W];
    t = tap_bus[SEED_W-1 -: LFSR_W];
    m_lfsr = (s == 32'd0) ? 32'd1 : s;
    m_tap  = (t == 32'd0) ? DEF_TAP : t;
  endtask

  // Model: GENE_W Galois steps, value = raw % (max+1), latency = GENE_W + raw/(max+1) + 1.
  task automatic model_draw(input logic [7:0] gmax, output logic [7:0] val, output int lat);
    int raw;
    int modv;
    for (int i = 0; i < GENE_W; i++)
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ m_tap) : (m_lfsr >> 1);
    raw  = int'(m_lfsr[7:0]);
    modv = int'(gmax) + 1;
    val  = 8'(raw % modv);
    lat  = GENE_W + raw / modv + 1;
  endtask

  // Issue one request from RUN and count edges from acceptance to gene_valid.
  task automatic do_draw(input logic [7:0] gmax, input bit hold, output logic [7:0] val, output int lat);
    bit got;
    check("pre_run_state", state_rng, 2'b10);
    gene_max = gmax;
    gene_req = 1'b1;
    tick;
    if (!hold) gene_req = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 400) begin
      tick;
      lat++;
      if (gene_valid) got = 1'b1;
    end
    check("valid_seen", got, 1'b1);
    val = gene_value;
  endtask

  task automatic draw_and_check(input logic [7:0] gmax, input bit hold);
    logic [7:0] ev, v;
    int el, l;
    model_draw(gmax, ev, el);
    do_draw(gmax, hold, v, l);
    check($sformatf("draw_value max=%0d", gmax), v, ev);
    check($sformatf("draw_latency max=%0d", gmax), l, el);
    if (!hold) begin
      tick;
      check("valid_one_cycle", gene_valid, 1'b0);
    end
  endtask

  // Drop seedIsReady, install slice 0 / tap word with pc=0, then reload.
  task automatic reseed_toggle(input logic [31:0] slice0, input logic [31:0] tapw);
    seed_rdy = 1'b0;
    tick;
    check("idle_after_drop", state_rng, 2'b00);
    seed_bus[31:0] = slice0;
    tap_bus[SEED_W-1 -: LFSR_W] = tapw;
    pc = 8'd0;
    seed_rdy = 1'b1;
    tick;
    check("load_state", state_rng, 2'b01);
    tick;
    check("run_state", state_rng, 2'b10);
    check("rng_ready_run", rng_ready, 1'b1);
    model_seed(pc);
  endtask

  initial begin
    logic [7:0] v, ev, prev, newpc, gm;
    int l, el, vcount;

    vecs[0] = '{32'h00000100, 32'hDEADBEEF, 8'hFF, 8'h01, 9};
    vecs[1] = '{32'h00000000, 32'h40010010, 8'hFF, 8'h04, 9};
    vecs[2] = '{32'h00000000, 32'h40010010, 8'h02, 8'h01, 10};
    vecs[3] = '{32'h0000FF00, 32'h12345678, 8'h09, 8'h05, 34};
    vecs[4] = '{32'h00000000, 32'h00000000, 8'h00, 8'h00, 11};

    rst_n    = 1'b0;
    seed_bus = '0;
    tap_bus  = '0;
    seed_rdy = 1'b0;
    pc       = 8'd0;
    gene_req = 1'b0;
    gene_max = 8'd0;
    tick;
    tick;
    check("reset_state", state_rng, 2'b00);
    check("reset_valid", gene_valid, 1'b0);
    check("reset_ready", rng_ready, 1'b0);
    check("reset_value", gene_value, 8'h00);
    rst_n = 1'b1;
    tick;
    check("idle_no_seed", state_rng, 2'b00);

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      reseed_toggle(vecs[i].slice, vecs[i].tapw);
      do_draw(vecs[i].gmax, 1'b0, v, l);
      check($sformatf("vec%0d_value", i), v, vecs[i].exp_val);
      check($sformatf("vec%0d_latency", i), l, vecs[i].exp_lat);
      tick;
      check($sformatf("vec%0d_valid_pulse", i), gene_valid, 1'b0);
    end

    // Random seeds, taps, population indices and bounds; re-seed by pc change.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < SEED_W / LFSR_W; i++)
        seed_bus[i*LFSR_W +: LFSR_W] = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      tap_bus[SEED_W-1 -: LFSR_W] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      newpc = 8'($urandom);
      if (newpc == pc) newpc = newpc + 8'd1;
      pc = newpc;
      tick;
      check("pc_reseed_load", state_rng, 2'b01);
      tick;
      check("pc_reseed_run", state_rng, 2'b10);
      model_seed(pc);
      for (int d = 0; d < 4; d++) draw_and_check(8'($urandom), 1'b0);
    end

    // Held request: back-to-back draws, valid coincides with RUN entry.
    draw_and_check(8'($urandom), 1'b1);
    check("b2b_run_at_valid", state_rng, 2'b10);
    draw_and_check(8'($urandom), 1'b1);
    gene_req = 1'b0;
    tick;
    check("b2b_valid_drop", gene_valid, 1'b0);

    // pc change during BUSY is deferred until the draw completes.
    seed_bus[63:32] = $urandom | 32'd1;
    reseed_toggle($urandom, $urandom);
    gm = 8'($urandom);
    model_draw(gm, ev, el);
    gene_max = gm;
    gene_req = 1'b1;
    tick;
    gene_req = 1'b0;
    l = 0;
    repeat (3) begin tick; l++; end
    pc = 8'd1;
    while (!gene_valid && l < 400) begin tick; l++; end
    check("defer_value", gene_value, ev);
    check("defer_latency", l, el);
    check("defer_run_at_valid", state_rng, 2'b10);
    tick;
    check("defer_load", state_rng, 2'b01);
    model_seed(pc);
    tick;
    check("defer_run", state_rng, 2'b10);
    check("defer_ready", rng_ready, 1'b1);
    draw_and_check(8'($urandom), 1'b0);

    // seedIsReady drop mid-STEP aborts the draw and holds gene_value.
    prev = gene_value;
    gene_max = 8'hFF;
    gene_req = 1'b1;
    tick;
    gene_req = 1'b0;
    repeat (3) tick;
    seed_rdy = 1'b0;
    tick;
    check("drop_idle", state_rng, 2'b00);
    check("drop_no_valid", gene_valid, 1'b0);
    vcount = 0;
    repeat (12) begin
      tick;
      if (gene_valid) vcount++;
    end
    check("drop_valid_count", vcount, 0);
    check("drop_value_held", gene_value, prev);
    seed_rdy = 1'b1;
    tick;
    check("rearm_load", state_rng, 2'b01);
    tick;
    check("rearm_run", state_rng, 2'b10);
    check("rearm_ready", rng_ready, 1'b1);
    model_seed(pc);
    draw_and_check(8'($urandom), 1'b0);

    // Asynchronous reset mid-REDUCE clears outputs without a clock edge.
    reseed_toggle(32'h0000FF00, 32'h12345678);
    gene_max = 8'd9;
    gene_req = 1'b1;
    tick;
    gene_req = 1'b0;
    repeat (12) tick;
    check("mid_reduce_busy", state_rng, 2'b11);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_state", state_rng, 2'b00);
    check("async_valid", gene_valid, 1'b0);
    check("async_ready", rng_ready, 1'b0);
    check("async_value", gene_value, 8'h00);
    tick;
    rst_n = 1'b1;
    tick;
    check("post_reset_load", state_rng, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
